program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: parses CA / length / data frames from a host link into
// instruction memory, then releases the core. Optional checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int PC_LENGTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic                 reload,
  input  logic [PC_LENGTH-1:0] program_counter,
  output logic [15:0]          instruction,
  output logic                 core_hold,
  output logic                 load_error,
  output logic [PC_LENGTH:0]   word_count,
  output logic [2:0]           state_dbg
);

  // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are both high;
  // the loader never stalls a frame, rx_ready only drops once RUN or ERROR is reached.

  localparam int DEPTH = 2 ** PC_LENGTH;
  localparam logic [16:0] MAX_LEN = 17'(DEPTH);
  localparam logic [7:0] SYNC_BYTE = 8'hCA;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4,
    S_CHECK   = 3'd5,
    S_RUN     = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [7:0]   lo_byte;
  logic [15:0]  len;
  logic [15:0]  mem [DEPTH];

  logic         accept;
  logic         abort;
  logic [15:0]  len_word;
  logic         len_bad;
  logic         last_word;
  logic         mem_we;

  assign accept    = rx_valid && rx_ready;
  assign abort     = reload && (state != S_IDLE);
  assign len_word  = {rx_data, lo_byte};
  assign len_bad   = (len_word == 16'd0) || ({1'b0, len_word} > MAX_LEN);
  assign last_word = (17'(word_count) + 17'd1) == {1'b0, len};
  assign mem_we    = rst && accept && !abort && (state == S_DATA_HI);
  assign state_dbg = state;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  assign csum_ok = (rx_data == csum);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else if (accept) begin
      case (state)
        S_IDLE:    if (rx_data == SYNC_BYTE) next_state = S_LEN_LO;
        S_LEN_LO:  next_state = S_LEN_HI;
        S_LEN_HI:  next_state = len_bad ? S_ERROR : S_DATA_LO;
        S_DATA_LO: next_state = S_DATA_HI;
        S_DATA_HI: begin
          if (!last_word) next_state = S_DATA_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          else            next_state = S_CHECK;
`else
          else            next_state = S_RUN;
`endif
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK:   next_state = csum_ok ? S_RUN : S_ERROR;
`endif
        default:   next_state = state;
      endcase
    end
  end

  always_comb begin
    rx_ready    = (state != S_RUN) && (state != S_ERROR);
    core_hold   = (state != S_RUN);
    load_error  = (state == S_ERROR);
    instruction = 16'h0000;
    if (state == S_RUN) instruction = mem[program_counter];
  end

  // Frame datapath: length, pending low byte, words written so far.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_byte    <= 8'h00;
      len        <= 16'h0000;
      word_count <= '0;
    end else if (abort) begin
      word_count <= '0;
    end else if (accept) begin
      case (state)
        S_IDLE:    if (rx_data == SYNC_BYTE) word_count <= '0;
        S_LEN_LO:  lo_byte <= rx_data;
        S_LEN_HI:  len <= len_word;
        S_DATA_LO: lo_byte <= rx_data;
        S_DATA_HI: word_count <= word_count + {{PC_LENGTH{1'b0}}, 1'b1};
        default:   ;
      endcase
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= 8'h00;
    end else if (abort) begin
      csum <= 8'h00;
    end else if (accept) begin
      if (state == S_IDLE && rx_data == SYNC_BYTE) csum <= 8'h00;
      else if (state == S_DATA_LO || state == S_DATA_HI) csum <= csum ^ rx_data;
    end
  end
`endif

  // Memory survives reset and reload; only frame writes change it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_count[PC_LENGTH-1:0]] <= {rx_data, lo_byte};
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a frame-level reference model and per-cycle compare.
module tb_program_loader;

  localparam int PC_LENGTH = 12;
  localparam int DEPTH = 2 ** PC_LENGTH;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 reload;
  logic [PC_LENGTH-1:0] pc;
  logic [15:0]          instruction;
  logic                 core_hold;
  logic                 load_error;
  logic [PC_LENGTH:0]   word_count;
  logic [2:0]           state_dbg;

  program_loader #(.PC_LENGTH(PC_LENGTH)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .reload(reload), .program_counter(pc), .instruction(instruction),
    .core_hold(core_hold), .load_error(load_error), .word_count(word_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model: position-in-frame counter, mode 0=holding 1=run 2=error
  int         m_mode = 0;
  int         m_wc = 0;
  int         cnt = -1;
  int         m_len = 0;
  logic [7:0] m_len_lo = 8'h00;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_xor = 8'h00;
  logic [15:0] model_mem [DEPTH];
  bit          known [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_wc = 0;
    cnt = -1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int d;
    if (cnt < 0) begin
      if (b == 8'hCA) begin
        cnt = 0;
        m_wc = 0;
        m_xor = 8'h00;
      end
    end else begin
      cnt++;
      if (cnt == 1) begin
        m_len_lo = b;
      end else if (cnt == 2) begin
        m_len = int'(b) * 256 + int'(m_len_lo);
        if (m_len == 0 || m_len > DEPTH) begin
          m_mode = 2;
          cnt = -1;
        end
      end else begin
        d = cnt - 3;
        if (d < 2 * m_len) begin
          m_xor ^= b;
          if (d % 2 == 1) begin
            model_mem[d / 2] = {b, m_prev};
            known[d / 2] = 1'b1;
            m_wc = d / 2 + 1;
            if (d == 2 * m_len - 1 && !CSUM_EN) begin
              m_mode = 1;
              cnt = -1;
            end
          end
        end else begin
          m_mode = (b == m_xor) ? 1 : 2;
          cnt = -1;
        end
      end
    end
    m_prev = b;
  endtask

  // driver tasks: called at posedge+1, return at the following posedge+1
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic pulse_reload(input bit with_byte, input logic [7:0] b);
    bit was_idle;
    was_idle = (m_mode == 0) && (cnt < 0);
    reload = 1'b1;
    rx_valid = with_byte;
    rx_data = b;
    @(posedge clk);
    #1;
    reload = 1'b0;
    rx_valid = 1'b0;
    if (was_idle) begin
      if (with_byte) model_byte(b);
    end else begin
      model_reset();
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every cycle outside reset the DUT must match the model
  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("rx_ready", 32'(rx_ready), 32'(m_mode == 0));
      chk("core_hold", 32'(core_hold), 32'(m_mode != 1));
      chk("load_error", 32'(load_error), 32'(m_mode == 2));
      chk("word_count", 32'(word_count), 32'(m_wc));
      if (m_mode != 1) chk("instruction_off", 32'(instruction), 32'h0);
      else if (known[pc]) chk("instruction_run", 32'(instruction), 32'(model_mem[pc]));
    end
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] x;
    logic [15:0] w;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    reload = 1'b0;
    pc = '0;
    repeat (3) @(posedge clk);
    settle();
    chk("reset_rx_ready", 32'(rx_ready), 32'h1);
    chk("reset_core_hold", 32'(core_hold), 32'h1);
    chk("reset_load_error", 32'(load_error), 32'h0);
    chk("reset_word_count", 32'(word_count), 32'h0);
    chk("reset_instruction", 32'(instruction), 32'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    realign();

    // basic two-word load
    q = '{8'hCA, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    if (CSUM_EN) q.push_back(8'h08);
    send_q(q);
    pc = 12'd1;
    settle();
    chk("t1_word_count", 32'(word_count), 32'd2);
    chk("t1_core_hold", 32'(core_hold), 32'h0);
    chk("t1_instr_pc1", 32'(instruction), 32'h5678);
    pc = 12'd0;
    settle();
    chk("t1_instr_pc0", 32'(instruction), 32'h1234);
    realign();
    for (int i = 0; i < 4; i++) begin
      pc = PC_LENGTH'(i);
      realign();
    end
    pulse_reload(1'b0, 8'h00);
    realign();

    // leading junk before the sync byte
    q = '{8'h00, 8'hFF, 8'hCA, 8'h01, 8'h00, 8'hAA, 8'hBB};
    if (CSUM_EN) q.push_back(8'h11);
    send_q(q);
    pc = 12'd0;
    settle();
    chk("t2_instr", 32'(instruction), 32'hBBAA);
    chk("t2_core_hold", 32'(core_hold), 32'h0);
    realign();
    pulse_reload(1'b0, 8'h00);

    // zero length
    send_q('{8'hCA, 8'h00, 8'h00});
    settle();
    chk("t3_load_error", 32'(load_error), 32'h1);
    chk("t3_rx_ready", 32'(rx_ready), 32'h0);
    chk("t3_instruction", 32'(instruction), 32'h0);
    realign();
    pulse_reload(1'b0, 8'h00);
    settle();
    chk("t3_error_cleared", 32'(load_error), 32'h0);
    realign();

    // reload mid-frame with a sync byte offered in the same cycle: it must be dropped
    send_q('{8'hCA, 8'h02, 8'h00, 8'h11});
    pulse_reload(1'b1, 8'hCA);
    settle();
    chk("t4_word_count", 32'(word_count), 32'h0);
    chk("t4_rx_ready", 32'(rx_ready), 32'h1);
    realign();
    q = '{8'h22, 8'hCA, 8'h01, 8'h00, 8'h5A, 8'hA5};
    if (CSUM_EN) q.push_back(8'hFF);
    send_q(q);
    settle();
    chk("t4_instr", 32'(instruction), 32'hA55A);
    realign();
    pulse_reload(1'b0, 8'h00);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_q('{8'hCA, 8'h01, 8'h00, 8'h11, 8'h22, 8'h00});
    settle();
    chk("t5_load_error", 32'(load_error), 32'h1);
    chk("t5_core_hold", 32'(core_hold), 32'h1);
    realign();
    pulse_reload(1'b0, 8'h00);
`endif

    // asynchronous reset mid-load
    send_q('{8'hCA, 8'h04, 8'h00, 8'h11});
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_word_count", 32'(word_count), 32'h0);
    chk("t6_core_hold", 32'(core_hold), 32'h1);
    chk("t6_rx_ready", 32'(rx_ready), 32'h1);
    chk("t6_instruction", 32'(instruction), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    realign();
    q = '{8'hCA, 8'h01, 8'h00, 8'hAB, 8'hCD};
    if (CSUM_EN) q.push_back(8'h66);
    send_q(q);
    pc = 12'd0;
    settle();
    chk("t6_instr", 32'(instruction), 32'hCDAB);
    realign();
    pulse_reload(1'b0, 8'h00);

    // maximum length frame
    send_q('{8'hCA, 8'h00, 8'h10});
    x = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'(i) ^ 16'hA5C3;
      x ^= w[7:0] ^ w[15:8];
      send_byte(w[7:0]);
      send_byte(w[15:8]);
    end
    if (CSUM_EN) send_byte(x);
    pc = 12'd4095;
    settle();
    chk("t7_word_count", 32'(word_count), 32'd4096);
    chk("t7_core_hold", 32'(core_hold), 32'h0);
    chk("t7_instr_last", 32'(instruction), 32'hAA3C);
    pc = 12'd0;
    settle();
    chk("t7_instr_first", 32'(instruction), 32'hA5C3);
    realign();
    pulse_reload(1'b0, 8'h00);

    // one beyond maximum
    send_q('{8'hCA, 8'h01, 8'h10});
    settle();
    chk("t8_load_error", 32'(load_error), 32'h1);
    chk("t8_word_count", 32'(word_count), 32'h0);
    realign();
    pulse_reload(1'b0, 8'h00);
    repeat (2) realign();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
